// File: rtl/aes128_cipher_iter.sv
// AES-128 encrypt engine with on-the-fly key expansion, RPC unrolled rounds per clock.
// Define AES_CBC_CHAIN_EN to add the CBC chain register and its ports.
module aes128_cipher_iter #(
  parameter int RPC = 1
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_text,
  input  logic [127:0] cipher_key,
`ifdef AES_CBC_CHAIN_EN
  input  logic         in_cbc,
  input  logic         in_iv_load,
  input  logic [127:0] iv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_text,
  output logic [3:0]   round_num,
  output logic         busy
);

  if (RPC != 1 && RPC != 2 && RPC != 5 && RPC != 10) begin : g_rpc_check
    $error("aes128_cipher_iter: RPC must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] RPC_4 = 4'(RPC);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;   4'd2: return 8'h02;   4'd3: return 8'h04;
      4'd4: return 8'h08;   4'd5: return 8'h10;   4'd6: return 8'h20;
      4'd7: return 8'h40;   4'd8: return 8'h80;   4'd9: return 8'h1b;
      4'd10: return 8'h36;  default: return 8'h00;
    endcase
  endfunction

  // Byte b of the block sits at [127-8b -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = sub_shift(s);
    if (!last)
      for (int c = 0; c < 4; c++)
        t[127 - 32*c -: 32] = mix_col(t[127 - 32*c -: 32]);
    return t ^ k;
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic         accept, finish;
  logic [127:0] st_p0, rk_p0, ct_p1;
  logic [3:0]   rnd_p0;
  logic [127:0] st_c, rk_c, round0;
  logic [3:0]   r_c;

`ifdef AES_CBC_CHAIN_EN
  logic [127:0] chain_q, chain_use;
  assign chain_use = in_iv_load ? iv : chain_q;
  assign round0    = plain_text ^ cipher_key ^ (in_cbc ? chain_use : 128'h0);
`else
  assign round0    = plain_text ^ cipher_key;
`endif

  always_comb begin
    st_c = st_p0;
    rk_c = rk_p0;
    r_c  = rnd_p0;
    for (int i = 1; i <= RPC; i++) begin
      r_c  = rnd_p0 + 4'(i);
      rk_c = key_exp(rk_c, rcon(r_c));
      st_c = enc_round(st_c, rk_c, r_c == 4'd10);
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    finish    = 1'b0;
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q != IDLE);
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = RUN;
      end
      RUN: if (rnd_p0 + RPC_4 == 4'd10) begin
        finish = 1'b1;
        fsm_d  = DONE;
      end
      DONE: if (out_ready) begin
        in_ready = 1'b1;
        fsm_d    = in_valid ? RUN : IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    accept = in_valid & in_ready;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // Round state/key registers (p0) and completed ciphertext (p1)
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_p0  <= '0;
      rk_p0  <= '0;
      rnd_p0 <= '0;
      ct_p1  <= '0;
    end else if (accept) begin
      st_p0  <= round0;
      rk_p0  <= cipher_key;
      rnd_p0 <= '0;
    end else if (fsm_q == RUN) begin
      st_p0  <= st_c;
      rk_p0  <= rk_c;
      rnd_p0 <= rnd_p0 + RPC_4;
      if (finish) ct_p1 <= st_c;
    end
  end

`ifdef AES_CBC_CHAIN_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                    chain_q <= '0;
    else if (accept && in_iv_load) chain_q <= iv;
    else if (finish)               chain_q <= st_c;
  end
`endif

  assign cipher_text = ct_p1;
  assign round_num   = rnd_p0;

endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Bench for aes128_cipher_iter: RPC=1 and RPC=2 instances against a byte-matrix AES model.
module tb_aes128_cipher_iter;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_pt, a_key, a_ct;
  logic [3:0]   a_rnd;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_pt, b_key, b_ct;
  logic [3:0]   b_rnd;
`ifdef AES_CBC_CHAIN_EN
  logic         a_cbc, a_iv_load, b_cbc, b_iv_load;
  logic [127:0] a_iv, b_iv;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb [256];

  aes128_cipher_iter #(.RPC(1)) u_dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .plain_text(a_pt), .cipher_key(a_key),
`ifdef AES_CBC_CHAIN_EN
    .in_cbc(a_cbc), .in_iv_load(a_iv_load), .iv(a_iv),
`endif
    .out_valid(a_out_valid), .out_ready(a_out_ready), .cipher_text(a_ct),
    .round_num(a_rnd), .busy(a_busy));

  aes128_cipher_iter #(.RPC(2)) u_dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .plain_text(b_pt), .cipher_key(b_key),
`ifdef AES_CBC_CHAIN_EN
    .in_cbc(b_cbc), .in_iv_load(b_iv_load), .iv(b_iv),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready), .cipher_text(b_ct),
    .round_num(b_rnd), .busy(b_busy));

  // GF(2^8) arithmetic; the S-box is derived from the field inverse and affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd != 10)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[r + 4*c];
          for (int r = 0; r < 4; r++)
            s[r + 4*c] = gmul(t[r], 8'h02) ^ gmul(t[(r+1)%4], 8'h03) ^ t[(r+2)%4] ^ t[(r+3)%4];
        end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][31 - 8*(b%4) -: 8];
    end
    o = '0;
    for (int b = 0; b < 16; b++) o[127 - 8*b -: 8] = s[b];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_a(input int budget, output int cyc);
    cyc = 0;
    while (!a_out_valid && cyc < budget) begin tick(); cyc++; end
    if (!a_out_valid) cyc = -1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_ct !== 128'h0) begin n_fail++; $display("FAIL reset_ct: got %h want 0", a_ct); end
    n_checks++; if (a_rnd !== 4'd0) begin n_fail++; $display("FAIL reset_round_num: got %0d want 0", a_rnd); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips_vector();
    int cyc;
    a_pt = 128'h00112233445566778899aabbccddeeff;
    a_key = 128'h000102030405060708090a0b0c0d0e0f;
    a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    n_checks++; if (a_busy !== 1'b1 || a_rnd !== 4'd0) begin n_fail++; $display("FAIL t1_after_accept: busy %b round %0d want 1/0", a_busy, a_rnd); end
    wait_a(20, cyc);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL t1_latency: got %0d want 10", cyc); end
    n_checks++; if (a_ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_fail++; $display("FAIL t1_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", a_ct); end
    n_checks++; if (a_rnd !== 4'd10) begin n_fail++; $display("FAIL t1_round_done: got %0d want 10", a_rnd); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL t1_to_idle: out_valid %b busy %b in_ready %b want 0/0/1", a_out_valid, a_busy, a_in_ready); end
  endtask

  task automatic test_rpc2();
    int cyc;
    logic [127:0] p, k, e;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin
        p = 128'h3243f6a8885a308d313198a2e0370734;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        e = 128'h3925841d02dc09fbdc118597196a0b32;
      end else begin
        p = rnd128(); k = rnd128(); e = model_encrypt(p, k);
      end
      b_pt = p; b_key = k; b_in_valid = 1'b1; b_out_ready = 1'b0;
      tick();
      b_in_valid = 1'b0;
      cyc = 0;
      while (!b_out_valid && cyc < 20) begin tick(); cyc++; end
      if (!b_out_valid) cyc = -1;
      n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL rpc2_latency[%0d]: got %0d want 5", n, cyc); end
      n_checks++; if (b_ct !== e) begin n_fail++; $display("FAIL rpc2_ct[%0d]: got %h want %h", n, b_ct, e); end
      n_checks++; if (b_rnd !== 4'd10) begin n_fail++; $display("FAIL rpc2_round[%0d]: got %0d want 10", n, b_rnd); end
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    int cyc, stall;
    logic [127:0] p, k, e;
    for (int n = 0; n < 10; n++) begin
      p = rnd128(); k = rnd128(); e = model_encrypt(p, k);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      a_pt = p; a_key = k; a_in_valid = 1'b1; a_out_ready = 1'b0;
      tick();
      a_in_valid = 1'b0;
      a_pt = rnd128(); a_key = rnd128();
      wait_a(20, cyc);
      n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 10", n, cyc); end
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) tick();
      n_checks++; if (a_ct !== e || a_out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rand_ct[%0d]: got %h valid %b want %h valid 1", n, a_ct, a_out_valid, e); end
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [127:0] p0, k0, p1, k1, e0, e1;
    p0 = rnd128(); k0 = rnd128(); e0 = model_encrypt(p0, k0);
    p1 = rnd128(); k1 = rnd128(); e1 = model_encrypt(p1, k1);
    a_pt = p0; a_key = k0; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    wait_a(20, cyc);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL bp_latency0: got %0d want 10", cyc); end
    a_pt = p1; a_key = k1; a_in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++; if (a_ct !== e0 || a_out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %h valid %b want %h valid 1", i, a_ct, a_out_valid, e0); end
      n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, a_in_ready); end
    end
    a_out_ready = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_rnd !== 4'd0) begin
      n_fail++; $display("FAIL bp_b2b_load: valid %b busy %b round %0d want 0/1/0", a_out_valid, a_busy, a_rnd); end
    wait_a(20, cyc);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL bp_latency1: got %0d want 10", cyc); end
    n_checks++; if (a_ct !== e1) begin n_fail++; $display("FAIL bp_ct1: got %h want %h", a_ct, e1); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_in_valid_during_run();
    logic [127:0] p, k, e;
    p = rnd128(); k = rnd128(); e = model_encrypt(p, k);
    a_pt = p; a_key = k; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) begin a_in_valid = 1'b1; a_pt = rnd128(); a_key = rnd128(); end
      if (c == 5) a_in_valid = 1'b0;
      tick();
      n_checks++; if (a_rnd !== 4'(c)) begin n_fail++; $display("FAIL run_round[%0d]: got %0d want %0d", c, a_rnd, c); end
    end
    tick();
    n_checks++; if (a_out_valid !== 1'b1 || a_ct !== e) begin
      n_fail++; $display("FAIL run_ignore_ct: got %h valid %b want %h valid 1", a_ct, a_out_valid, e); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    a_pt = rnd128(); a_key = rnd128(); a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_checks++; if (a_rnd !== 4'd4) begin n_fail++; $display("FAIL rst_pre_round: got %0d want 4", a_rnd); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_busy !== 1'b0 || a_rnd !== 4'd0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_ctrl: busy %b round %0d in_ready %b valid %b want 0/0/1/0", a_busy, a_rnd, a_in_ready, a_out_valid); end
    n_checks++; if (a_ct !== 128'h0) begin n_fail++; $display("FAIL rst_async_ct: got %h want 0", a_ct); end
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin tick(); if (a_out_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_out_valid: got %b want 0", seen); end
    n_checks++; if (a_in_ready !== 1'b1 || a_rnd !== 4'd0) begin
      n_fail++; $display("FAIL rst_after: in_ready %b round %0d want 1/0", a_in_ready, a_rnd); end
    test_fips_vector();
  endtask

`ifdef AES_CBC_CHAIN_EN
  task automatic test_cbc();
    int cyc;
    a_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a_iv  = 128'h000102030405060708090a0b0c0d0e0f;
    a_pt  = 128'h6bc1bee22e409f96e93d7e117393172a;
    a_cbc = 1'b1; a_iv_load = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0; a_iv_load = 1'b0; a_iv = rnd128();
    wait_a(20, cyc);
    n_checks++; if (a_ct !== 128'h7649abac8119b246cee98e9b12e9197d) begin
      n_fail++; $display("FAIL cbc_ct0: got %h want 7649abac8119b246cee98e9b12e9197d", a_ct); end
    a_pt = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_cbc = 1'b0;
    wait_a(20, cyc);
    n_checks++; if (a_ct !== 128'h5086cb9b507219ee95db113a917678b2) begin
      n_fail++; $display("FAIL cbc_ct1: got %h want 5086cb9b507219ee95db113a917678b2", a_ct); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask
`endif

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_pt = '0; a_key = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_pt = '0; b_key = '0;
`ifdef AES_CBC_CHAIN_EN
    a_cbc = 1'b0; a_iv_load = 1'b0; a_iv = '0;
    b_cbc = 1'b0; b_iv_load = 1'b0; b_iv = '0;
`endif
    build_sbox();
    test_reset();
    test_fips_vector();
    test_rpc2();
    test_random();
    test_backpressure();
    test_in_valid_during_run();
    test_reset_mid_run();
`ifdef AES_CBC_CHAIN_EN
    test_cbc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
